// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter sharing one simplified AXI-Lite master port among N_REQ requesters.
// Reads are routed back by the requester index carried in rid; write acks by an in-order FIFO.
module axi_lite_rr_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned UID_W      = 2,
    parameter int unsigned MAX_WR_OUT = 4,
    localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned ID_W      = UID_W + IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*UID_W-1:0]    req_id,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [UID_W-1:0]          rsp_id,
    output logic [ADDR_W-1:0]         araddr,
    output logic [ID_W-1:0]           arid,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_W-1:0]         awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_W-1:0]         wdata,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [DATA_W-1:0]         rdata,
    input  logic [ID_W-1:0]           rid,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      err_unexpected_b
);

    localparam int unsigned PTR_W = (MAX_WR_OUT > 1) ? $clog2(MAX_WR_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_WR_OUT + 1);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  wf_mem [MAX_WR_OUT];
    logic [PTR_W-1:0]  wf_wr_ptr;
    logic [PTR_W-1:0]  wf_rd_ptr;
    logic [CNT_W-1:0]  wf_count;
    logic [IDX_W-1:0]  wf_head;
    logic              wf_empty;
    logic              wf_room;
    logic              wf_push;
    logic              b_pop;
    logic              b_deliver;
    logic [IDX_W-1:0]  r_idx;
    logic              r_ok;
    logic              r_hits_head;
    logic              issue_free;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand;
    logic              gnt_write;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [UID_W-1:0]  gnt_uid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_WR_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Response routing: a read to the FIFO head blocks that cycle's write ack.
    assign r_idx            = rid[ID_W-1:UID_W];
    assign r_ok             = 32'(r_idx) < N_REQ;
    assign wf_empty         = (wf_count == '0);
    assign wf_head          = wf_mem[wf_rd_ptr];
    assign r_hits_head      = rvalid && r_ok && !wf_empty && (r_idx == wf_head);
    assign b_deliver        = bvalid && !wf_empty && !r_hits_head;
    assign b_pop            = bvalid && bready && !wf_empty;
    assign err_unexpected_b = bvalid && wf_empty;
    assign rsp_write        = b_deliver;
    assign rsp_data         = rdata;
    assign rsp_id           = rid[UID_W-1:0];

    always_comb begin
        rsp_valid = '0;
        rready    = rvalid && !r_ok;
        bready    = bvalid && wf_empty;
        for (int k = 0; k < N_REQ; k++) begin
            if (rvalid && r_ok && (r_idx == IDX_W'(k))) begin
                rsp_valid[k] = 1'b1;
                rready       = rsp_ready[k];
            end
            if (b_deliver && (wf_head == IDX_W'(k))) begin
                rsp_valid[k] = 1'b1;
                bready       = rsp_ready[k];
            end
        end
    end

    // Grant only when every pending AXI handshake finishes this cycle.
    assign issue_free = (!arvalid || arready) && (!awvalid || awready) && (!wvalid || wready);
    assign wf_room    = (32'(wf_count) - 32'(b_pop)) < MAX_WR_OUT;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + 32'(i)) % N_REQ);
            if (!gnt_any && issue_free && req_valid[cand] && (!req_write[cand] || wf_room)) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    assign gnt_write = req_write[gnt_idx];
    assign gnt_addr  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
    assign gnt_data  = req_data[32'(gnt_idx)*DATA_W +: DATA_W];
    assign gnt_uid   = req_id[32'(gnt_idx)*UID_W +: UID_W];
    assign wf_push   = gnt_any && gnt_write;

    // Issue stage: a new grant overrides the clear from a completing handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            araddr  <= '0;
            arid    <= '0;
            awaddr  <= '0;
            wdata   <= '0;
            rr_ptr  <= '0;
        end else begin
            if (arvalid && arready) arvalid <= 1'b0;
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (gnt_write) begin
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    awaddr  <= gnt_addr;
                    wdata   <= gnt_data;
                end else begin
                    arvalid <= 1'b1;
                    araddr  <= gnt_addr;
                    arid    <= {gnt_idx, gnt_uid};
                end
            end
        end
    end

    // Write-order FIFO of requester indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            wf_wr_ptr <= '0;
            wf_rd_ptr <= '0;
            wf_count  <= '0;
        end else begin
            if (wf_push) wf_wr_ptr <= ptr_inc(wf_wr_ptr);
            if (b_pop)   wf_rd_ptr <= ptr_inc(wf_rd_ptr);
            wf_count <= wf_count + CNT_W'(wf_push) - CNT_W'(b_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wf_push) wf_mem[wf_wr_ptr] <= gnt_idx;
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter; expected AXI issues and responses are
// queued by the stimulus and checked by a negedge monitor.
module tb_axi_lite_rr_arbiter;

    localparam int unsigned N_REQ      = 2;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned UID_W      = 2;
    localparam int unsigned ID_W       = 3;
    localparam int unsigned MAX_WR_OUT = 4;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ*UID_W-1:0]  req_id;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic                    rsp_write;
    logic [DATA_W-1:0]       rsp_data;
    logic [UID_W-1:0]        rsp_id;
    logic [ADDR_W-1:0]       araddr;
    logic [ID_W-1:0]         arid;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_W-1:0]       awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_W-1:0]       wdata;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_W-1:0]       rdata;
    logic [ID_W-1:0]         rid;
    logic                    rvalid;
    logic                    rready;
    logic                    bvalid;
    logic                    bready;
    logic                    err_unexpected_b;

    axi_lite_rr_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .UID_W(UID_W), .MAX_WR_OUT(MAX_WR_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .araddr(araddr), .arid(arid), .arvalid(arvalid), .arready(arready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rid(rid), .rvalid(rvalid), .rready(rready),
        .bvalid(bvalid), .bready(bready), .err_unexpected_b(err_unexpected_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned who;
        logic        wr;
        logic [31:0] data;
        logic [1:0]  id;
    } rsp_t;

    rsp_t        exp_rsp[$];
    logic [34:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT handshake with no expected entry queued", name);
    endtask

    // Monitor: compares every AXI issue handshake and every delivered response.
    rsp_t        mr;
    logic [34:0] me;
    logic [31:0] mw;
    always @(negedge clk) begin
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) missing("ar_unexpected");
            else begin me = exp_ar.pop_front(); chk("ar_addr_id", {araddr, arid}, me); end
        end
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) missing("aw_unexpected");
            else begin mw = exp_aw.pop_front(); chk("aw_addr", awaddr, mw); end
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) missing("w_unexpected");
            else begin mw = exp_w.pop_front(); chk("w_data", wdata, mw); end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (rsp_valid[k] && rsp_ready[k]) begin
                if (exp_rsp.size() == 0) missing("rsp_unexpected");
                else begin
                    mr = exp_rsp.pop_front();
                    chk("rsp_target", k, mr.who);
                    chk("rsp_write", rsp_write, mr.wr);
                    if (!mr.wr) begin
                        chk("rsp_data", rsp_data, mr.data);
                        chk("rsp_id", rsp_id, mr.id);
                    end
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic v, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [1:0] id);
        req_valid[k]         = v;
        req_write[k]         = wr;
        req_addr[k*32 +: 32] = a;
        req_data[k*32 +: 32] = d;
        req_id[k*2 +: 2]     = id;
    endtask

    task automatic push_rsp(input int unsigned who, input logic wr, input logic [31:0] d, input logic [1:0] id);
        rsp_t r;
        r.who = who; r.wr = wr; r.data = d; r.id = id;
        exp_rsp.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int exp_k;
    int n_wr;
    int pulses;

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_data = '0; req_id = '0;
        rsp_ready = '0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rdata = '0; rid = '0; rvalid = 1'b0; bvalid = 1'b0;
        next; next;
        mid;
        chk("reset_axi_valids", {arvalid, awvalid, wvalid}, 3'b000);
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_rsp_side", {rsp_valid, rready, bready, err_unexpected_b}, 5'b0);
        next;
        rst = 1'b0;

        // Single read from requester 0, then its out-of-order style response.
        arready = 1'b1;
        set_req(0, 1, 0, 32'h10, 32'h0, 2'd1);
        exp_ar.push_back({32'h10, 3'b001});
        mid; chk("t1_grant", req_ready, 2'b01);
        next; set_req(0, 0, 0, 32'h10, 32'h0, 2'd1);
        mid; chk("t1_arvalid", arvalid, 1'b1);
        next;
        rvalid = 1'b1; rdata = 32'hA5; rid = 3'b001; rsp_ready = 2'b01;
        push_rsp(0, 0, 32'hA5, 2'd1);
        mid; chk("t1_ar_drop", arvalid, 1'b0); chk("t1_rsp_valid", rsp_valid, 2'b01);
        next; rvalid = 1'b0; rsp_ready = 2'b00;

        // Both requesters read continuously; pointer sits at 1 after the first grant.
        set_req(0, 1, 0, 32'h100, 32'h0, 2'd2);
        set_req(1, 1, 0, 32'h200, 32'h0, 2'd3);
        exp_k = 1;
        for (int i = 0; i < 8; i++) begin
            mid;
            chk("t2_rr_grant", req_ready, (exp_k == 1) ? 2'b10 : 2'b01);
            exp_ar.push_back(exp_k == 1 ? {32'h200, 3'b111} : {32'h100, 3'b010});
            exp_k = 1 - exp_k;
            next;
        end
        req_valid = '0;
        next;

        // Requester 1 writes until the 4-deep order FIFO fills; no B returned yet.
        awready = 1'b1; wready = 1'b1;
        n_wr = 0; pulses = 0;
        set_req(1, 1, 1, 32'h1000, 32'hC0DE0000, 2'd0);
        for (int i = 0; i < 10; i++) begin
            mid;
            if (req_ready[1]) begin
                exp_aw.push_back(32'h1000 + 32'(n_wr * 4));
                exp_w.push_back(32'hC0DE0000 + 32'(n_wr));
                pulses++; n_wr++;
            end
            next;
            set_req(1, 1, 1, 32'h1000 + 32'(n_wr * 4), 32'hC0DE0000 + 32'(n_wr), 2'd0);
        end
        chk("t3_pulses_before_b", pulses, 4);
        bvalid = 1'b1; rsp_ready = 2'b10;
        push_rsp(1, 1, 32'h0, 2'd0);
        mid;
        chk("t3_release_same_cycle", req_ready, 2'b10);
        chk("t3_bready", bready, 1'b1);
        if (req_ready[1]) begin
            exp_aw.push_back(32'h1000 + 32'(n_wr * 4));
            exp_w.push_back(32'hC0DE0000 + 32'(n_wr));
        end
        next; set_req(1, 0, 1, 32'h0, 32'h0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            push_rsp(1, 1, 32'h0, 2'd0);
            mid; chk("t3_drain_bready", bready, 1'b1);
            next;
        end
        bvalid = 1'b0; rsp_ready = 2'b00;

        // AW stalls three cycles while W goes through; a pending read must wait.
        awready = 1'b0; wready = 1'b1; arready = 1'b1;
        set_req(0, 1, 1, 32'h40, 32'hD0, 2'd0);
        exp_aw.push_back(32'h40); exp_w.push_back(32'hD0);
        mid; chk("t4_grant_write", req_ready, 2'b01);
        next;
        set_req(0, 0, 1, 32'h40, 32'hD0, 2'd0);
        set_req(1, 1, 0, 32'h300, 32'h0, 2'd0);
        for (int c = 1; c <= 3; c++) begin
            mid;
            chk("t4_awvalid_held", awvalid, 1'b1);
            chk("t4_awaddr_stable", awaddr, 32'h40);
            chk("t4_wvalid", wvalid, (c == 1) ? 1'b1 : 1'b0);
            chk("t4_no_grant", req_ready, 2'b00);
            next;
        end
        awready = 1'b1;
        exp_ar.push_back({32'h300, 3'b100});
        mid; chk("t4_awvalid_last", awvalid, 1'b1); chk("t4_grant_on_final_hs", req_ready, 2'b10);
        next; set_req(1, 0, 0, 32'h300, 32'h0, 2'd0);
        mid; chk("t4_aw_dropped", awvalid, 1'b0); chk("t4_ar_issued", arvalid, 1'b1);
        next;

        // R and B both for requester 0: read first, write ack next cycle.
        rvalid = 1'b1; rid = 3'b010; rdata = 32'h5A; bvalid = 1'b1; rsp_ready = 2'b01;
        push_rsp(0, 0, 32'h5A, 2'd2);
        mid; chk("t5_bready_blocked", bready, 1'b0); chk("t5_rsp_valid", rsp_valid, 2'b01);
        next;
        rvalid = 1'b0;
        push_rsp(0, 1, 32'h0, 2'd0);
        mid; chk("t5_bready", bready, 1'b1); chk("t5_rsp_write", rsp_write, 1'b1);
        next; bvalid = 1'b0; rsp_ready = 2'b00;

        // Stray B with nothing outstanding.
        bvalid = 1'b1;
        mid;
        chk("t6_bready_drain", bready, 1'b1);
        chk("t6_err_pulse", err_unexpected_b, 1'b1);
        chk("t6_no_rsp", rsp_valid, 2'b00);
        next; bvalid = 1'b0;
        mid; chk("t6_err_clear", err_unexpected_b, 1'b0);
        next;

        // Reset while a write is pending on AW/W.
        awready = 1'b0; wready = 1'b0;
        set_req(0, 1, 1, 32'h80, 32'h11, 2'd0);
        mid; chk("t7_grant", req_ready, 2'b01);
        next; set_req(0, 0, 1, 32'h80, 32'h11, 2'd0);
        mid; chk("t7_awvalid_pending", awvalid, 1'b1);
        next; rst = 1'b1;
        next; rst = 1'b0;
        mid; chk("t7_valids_cleared", {arvalid, awvalid, wvalid}, 3'b000);
        next; bvalid = 1'b1;
        mid; chk("t7_fifo_empty", err_unexpected_b, 1'b1);
        next; bvalid = 1'b0; awready = 1'b1; wready = 1'b1;
        next; next;

        chk("queues_drained", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_rsp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
